pc_sequencer: RTL and testbench

Multi-cycle control FSM for the picoMIPS core that sequences the program counter, instruction register and register-file write strobe. Each cycle it decides whether the PC increments, loads a branch target, or holds. It also stalls the core on an input-wait instruction using a valid/ready handshake. It sits between instruction memory (opcode and target fields) and the PC/ALU datapath, and replaces the ad-hoc increment gating with an explicit sequencer.

---
 rtl/pc_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Control sequencer for the picoMIPS core. Steps through IDLE -> FETCH ->
// EXEC (-> WAIT | HALT) and decides each cycle whether the PC increments,
// loads a branch target or holds. It also drives the register-file write
// strobe and stalls the core on an input-wait instruction.
//
// Handshake: in_ready is high only while the sequencer sits unstalled in
// WAIT; a transfer happens in the cycle where in_ready and in_valid are
// both 1, and that same cycle carries rf_we and pc_incr.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   opcode     opcode field from instruction memory (valid in FETCH)
//   target     branch/jump target field (valid in FETCH)
//   flag       ALU zero flag, used combinationally in EXEC
//   stall      freeze request for FETCH/EXEC/WAIT
//   in_valid   external input data valid
//   ir_en      instruction-register load strobe
//   pc_incr    PC increment strobe
//   pc_load    PC load strobe (PC takes pc_target)
//   pc_target  registered branch target
//   rf_we      register-file write strobe
//   in_ready   sequencer is waiting for input
//   halted     core stopped
//   illegal    sticky illegal-opcode flag
//   retired    saturating count of completed instructions
//   dbg_state  current sequencer state, for observation only
module pc_sequencer #(
    parameter int Psize = 6,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       opcode,
    input  logic [Psize-1:0] target,
    input  logic             flag,
    input  logic             stall,
    input  logic             in_valid,
    output logic             ir_en,
    output logic             pc_incr,
    output logic             pc_load,
    output logic [Psize-1:0] pc_target,
    output logic             rf_we,
    output logic             in_ready,
    output logic             halted,
    output logic             illegal,
    output logic [CNTW-1:0]  retired,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WAIT  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ALU  = 3'b001;
    localparam logic [2:0] OP_BEQ  = 3'b010;
    localparam logic [2:0] OP_BNE  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_WAIT = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_op;
    logic [Psize-1:0] r_pc_target;
    logic [CNTW-1:0]  r_retired;
    logic             r_illegal;

    logic w_ir_en;
    logic w_pc_incr;
    logic w_pc_load;
    logic w_rf_we;
    logic w_in_ready;
    logic w_halted;
    logic w_latch;
    logic w_set_illegal;

    // Next-state and strobe decode. Stall only affects the three working
    // states; it leaves the state unchanged and suppresses every strobe.
    always_comb begin
        w_next_state  = r_state;
        w_ir_en       = 1'b0;
        w_pc_incr     = 1'b0;
        w_pc_load     = 1'b0;
        w_rf_we       = 1'b0;
        w_in_ready    = 1'b0;
        w_halted      = 1'b0;
        w_latch       = 1'b0;
        w_set_illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (!stall) begin
                    w_ir_en      = 1'b1;
                    w_latch      = 1'b1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    w_next_state = S_FETCH;
                    case (r_op)
                        OP_NOP: w_pc_incr = 1'b1;
                        OP_ALU: begin
                            w_rf_we   = 1'b1;
                            w_pc_incr = 1'b1;
                        end
                        OP_BEQ: begin
                            w_pc_load = flag;
                            w_pc_incr = !flag;
                        end
                        OP_BNE: begin
                            w_pc_load = !flag;
                            w_pc_incr = flag;
                        end
                        OP_JMP:  w_pc_load    = 1'b1;
                        OP_WAIT: w_next_state = S_WAIT;
                        OP_HALT: w_next_state = S_HALT;
                        OP_ILL: begin
                            w_pc_incr     = 1'b1;
                            w_set_illegal = 1'b1;
                        end
                        default: w_next_state = S_FETCH;
                    endcase
                end
            end
            S_WAIT: begin
                if (!stall) begin
                    w_in_ready = 1'b1;
                    if (in_valid) begin
                        w_rf_we      = 1'b1;
                        w_pc_incr    = 1'b1;
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= 3'b000;
            r_pc_target <= '0;
            r_retired   <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_op        <= opcode;
                r_pc_target <= target;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            // Count completions; hold at all-ones instead of wrapping.
            if ((w_pc_incr || w_pc_load) && (r_retired != {CNTW{1'b1}})) begin
                r_retired <= r_retired + CNTW'(1);
            end
        end
    end

    assign ir_en     = w_ir_en;
    assign pc_incr   = w_pc_incr;
    assign pc_load   = w_pc_load;
    assign pc_target = r_pc_target;
    assign rf_we     = w_rf_we;
    assign in_ready  = w_in_ready;
    assign halted    = w_halted;
    assign illegal   = r_illegal;
    assign retired   = r_retired;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer. Expected outputs come from an
// instruction-level model: each instruction is a FETCH cycle, an EXEC
// cycle whose strobes follow the opcode table, and optional WAIT/HALT
// cycles; retired is modelled as a plain saturating integer.
module tb_pc_sequencer;

  localparam int PS   = 6;
  localparam int CW   = 4;
  localparam int MAXR = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    opcode = 3'b000;
  logic [PS-1:0] target = '0;
  logic          flag = 1'b0;
  logic          stall = 1'b0;
  logic          in_valid = 1'b0;
  logic          ir_en, pc_incr, pc_load, rf_we, in_ready, halted, illegal;
  logic [PS-1:0] pc_target;
  logic [CW-1:0] retired;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int m_retired = 0;
  bit m_illegal = 1'b0;

  // Output vector order: {ir_en, pc_incr, pc_load, rf_we, in_ready, halted}
  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_FETCH = 6'b100000;
  localparam logic [5:0] O_INCR  = 6'b010000;
  localparam logic [5:0] O_LOAD  = 6'b001000;
  localparam logic [5:0] O_RFWE  = 6'b000100;
  localparam logic [5:0] O_READY = 6'b000010;
  localparam logic [5:0] O_HALT  = 6'b000001;

  pc_sequencer #(.Psize(PS), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .target(target), .flag(flag),
    .stall(stall), .in_valid(in_valid), .ir_en(ir_en), .pc_incr(pc_incr),
    .pc_load(pc_load), .pc_target(pc_target), .rf_we(rf_we),
    .in_ready(in_ready), .halted(halted), .illegal(illegal),
    .retired(retired), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [5:0] outs();
    return {ir_en, pc_incr, pc_load, rf_we, in_ready, halted};
  endfunction

  function automatic logic [5:0] exec_expect(input logic [2:0] op, input logic f);
    case (op)
      3'b000:  return O_INCR;
      3'b001:  return O_INCR | O_RFWE;
      3'b010:  return f ? O_LOAD : O_INCR;
      3'b011:  return f ? O_INCR : O_LOAD;
      3'b100:  return O_LOAD;
      3'b111:  return O_INCR;
      default: return O_NONE;
    endcase
  endfunction

  task automatic model_retire();
    if (m_retired < MAXR) m_retired++;
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs at the start of a cycle and advance to the sample point.
  task automatic drive(input logic st, input logic iv, input logic fl,
                       input logic [2:0] op, input logic [PS-1:0] tg);
    stall = st; in_valid = iv; flag = fl; opcode = op; target = tg;
    #4;
  endtask

  // Leaves the bench at the start of the IDLE cycle after reset.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; stall = 1'b0; in_valid = 1'b0; flag = 1'b0;
    opcode = 3'b000; target = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_retired = 0;
    m_illegal = 1'b0;
  endtask

  // Reset and step through IDLE; leaves the bench at the first FETCH.
  task automatic to_fetch();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), PS'($urandom));
      n_checks++;
      if ({outs(), retired, illegal, pc_target} !== '0) begin
        n_errors++;
        $display("FAIL reset_state: got outs=%b ret=%0d ill=%b tgt=%h, required all zero",
                 outs(), retired, illegal, pc_target);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_sequence();
    logic [2:0]    ops [3];
    logic [5:0]    exp [7];
    ops = '{3'b000, 3'b001, 3'b100};
    exp = '{O_NONE, O_FETCH, O_INCR, O_FETCH, O_INCR | O_RFWE, O_FETCH, O_LOAD};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 1'b0, 1'b0, (c % 2 == 1) ? ops[c / 2] : 3'b000, 6'h2A);
      n_checks++;
      if (outs() !== exp[c]) begin
        n_errors++;
        $display("FAIL seq_cycle%0d: got %b required %b", c, outs(), exp[c]);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
    n_checks++;
    if (retired !== CW'(3) || pc_target !== 6'h2A || outs() !== O_FETCH) begin
      n_errors++;
      $display("FAIL seq_end: got ret=%0d tgt=%h outs=%b required ret=3 tgt=2a outs=%b",
               retired, pc_target, outs(), O_FETCH);
    end
  endtask

  task automatic test_branch();
    logic [2:0] op;
    logic       fl;
    to_fetch();
    for (int r = 0; r < 4; r++) begin
      op = (r < 2) ? 3'b010 : 3'b011;
      fl = (r % 2 == 0);
      drive(1'b0, 1'b0, 1'b0, op, 6'h10);
      tick();
      drive(1'b0, 1'b0, fl, 3'($urandom), PS'($urandom));
      n_checks++;
      if (outs() !== exec_expect(op, fl) || pc_target !== 6'h10 || (pc_incr && pc_load)) begin
        n_errors++;
        $display("FAIL branch_op%0d_flag%0d: got %b tgt=%h required %b tgt=10",
                 op, fl, outs(), pc_target, exec_expect(op, fl));
      end
      tick();
    end
  endtask

  task automatic test_wait();
    int ready_cycles;
    ready_cycles = 0;
    to_fetch();
    drive(1'b0, 1'b0, 1'b0, 3'b101, '0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 3'b000, '0);
    n_checks++;
    if (outs() !== O_NONE) begin
      n_errors++;
      $display("FAIL wait_exec: got %b required %b", outs(), O_NONE);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'($urandom), 3'($urandom), PS'($urandom));
      if (in_ready) ready_cycles++;
      n_checks++;
      if (outs() !== O_READY) begin
        n_errors++;
        $display("FAIL wait_idle%0d: got %b required %b", i, outs(), O_READY);
      end
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 3'b000, '0);
    if (in_ready) ready_cycles++;
    n_checks++;
    if (outs() !== (O_READY | O_RFWE | O_INCR)) begin
      n_errors++;
      $display("FAIL wait_handshake: got %b required %b", outs(), O_READY | O_RFWE | O_INCR);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
    n_checks++;
    if (outs() !== O_FETCH || ready_cycles != 6 || retired !== CW'(1)) begin
      n_errors++;
      $display("FAIL wait_after: got outs=%b ready=%0d ret=%0d required outs=%b ready=6 ret=1",
               outs(), ready_cycles, retired, O_FETCH);
    end
  endtask

  task automatic test_wait_stall();
    to_fetch();
    drive(1'b0, 1'b0, 1'b0, 3'b101, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'b000, '0);
      n_checks++;
      if (outs() !== O_NONE || retired !== CW'(0)) begin
        n_errors++;
        $display("FAIL wait_stall%0d: got %b ret=%0d required %b ret=0", i, outs(), retired, O_NONE);
      end
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 3'b000, '0);
    n_checks++;
    if (outs() !== (O_READY | O_RFWE | O_INCR)) begin
      n_errors++;
      $display("FAIL wait_unstall: got %b required %b", outs(), O_READY | O_RFWE | O_INCR);
    end
    tick();
  endtask

  task automatic test_illegal();
    to_fetch();
    drive(1'b0, 1'b0, 1'b0, 3'b111, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
    n_checks++;
    if (outs() !== O_INCR || illegal !== 1'b0) begin
      n_errors++;
      $display("FAIL illegal_exec: got %b ill=%b required %b ill=0", outs(), illegal, O_INCR);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 3'b001, '0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
    n_checks++;
    if (illegal !== 1'b1 || retired !== CW'(3)) begin
      n_errors++;
      $display("FAIL illegal_sticky: got ill=%b ret=%0d required ill=1 ret=3", illegal, retired);
    end
    to_fetch();
    drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
    n_checks++;
    if (illegal !== 1'b0) begin
      n_errors++;
      $display("FAIL illegal_clear: got %b required 0", illegal);
    end
  endtask

  task automatic test_random();
    logic [2:0]    op_tab [7];
    logic [2:0]    op;
    logic [PS-1:0] tg;
    logic          fl;
    logic [5:0]    exp;
    int            nsf, nse, nw, nsw;
    op_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};
    to_fetch();
    for (int k = 0; k < 40; k++) begin
      op  = op_tab[$urandom_range(0, 6)];
      tg  = PS'($urandom);
      fl  = 1'($urandom);
      nsf = $urandom_range(0, 2);
      nse = $urandom_range(0, 2);
      nw  = $urandom_range(0, 3);
      nsw = $urandom_range(0, 2);
      for (int i = 0; i < nsf; i++) begin
        drive(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), PS'($urandom));
        n_checks++;
        if (outs() !== O_NONE) begin
          n_errors++;
          $display("FAIL rnd%0d_fetch_stall: got %b required %b", k, outs(), O_NONE);
        end
        tick();
      end
      drive(1'b0, 1'($urandom), 1'($urandom), op, tg);
      n_checks++;
      if (outs() !== O_FETCH || retired !== CW'(m_retired) || illegal !== m_illegal) begin
        n_errors++;
        $display("FAIL rnd%0d_fetch: got outs=%b ret=%0d ill=%b required outs=%b ret=%0d ill=%b",
                 k, outs(), retired, illegal, O_FETCH, m_retired, m_illegal);
      end
      tick();
      for (int i = 0; i < nse; i++) begin
        drive(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), PS'($urandom));
        n_checks++;
        if (outs() !== O_NONE || pc_target !== tg) begin
          n_errors++;
          $display("FAIL rnd%0d_exec_stall: got %b tgt=%h required %b tgt=%h",
                   k, outs(), pc_target, O_NONE, tg);
        end
        tick();
      end
      drive(1'b0, 1'($urandom), fl, 3'($urandom), PS'($urandom));
      exp = exec_expect(op, fl);
      n_checks++;
      if (outs() !== exp || pc_target !== tg) begin
        n_errors++;
        $display("FAIL rnd%0d_exec_op%0d: got %b tgt=%h required %b tgt=%h",
                 k, op, outs(), pc_target, exp, tg);
      end
      if (exp[4] || exp[3]) model_retire();
      if (op == 3'b111) m_illegal = 1'b1;
      tick();
      if (op == 3'b101) begin
        for (int i = 0; i < nw; i++) begin
          drive(1'b0, 1'b0, 1'($urandom), 3'($urandom), PS'($urandom));
          n_checks++;
          if (outs() !== O_READY) begin
            n_errors++;
            $display("FAIL rnd%0d_wait: got %b required %b", k, outs(), O_READY);
          end
          tick();
        end
        for (int i = 0; i < nsw; i++) begin
          drive(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), PS'($urandom));
          n_checks++;
          if (outs() !== O_NONE) begin
            n_errors++;
            $display("FAIL rnd%0d_wait_stall: got %b required %b", k, outs(), O_NONE);
          end
          tick();
        end
        drive(1'b0, 1'b1, 1'($urandom), 3'($urandom), PS'($urandom));
        n_checks++;
        if (outs() !== (O_READY | O_RFWE | O_INCR)) begin
          n_errors++;
          $display("FAIL rnd%0d_handshake: got %b required %b", k, outs(), O_READY | O_RFWE | O_INCR);
        end
        model_retire();
        tick();
      end
    end
  endtask

  task automatic test_halt();
    to_fetch();
    drive(1'b0, 1'b0, 1'b0, 3'b110, '0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 3'b000, '0);
    n_checks++;
    if (outs() !== O_NONE) begin
      n_errors++;
      $display("FAIL halt_exec: got %b required %b", outs(), O_NONE);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), PS'($urandom));
      n_checks++;
      if (outs() !== O_HALT) begin
        n_errors++;
        $display("FAIL halt_hold%0d: got %b required %b", i, outs(), O_HALT);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
    reset = 1'b1;
    #1;
    n_checks++;
    if (outs() !== O_NONE) begin
      n_errors++;
      $display("FAIL halt_async_reset: got %b required %b", outs(), O_NONE);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_async_reset();
    to_fetch();
    drive(1'b0, 1'b0, 1'b0, 3'b111, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b001, 6'h3F);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
    n_checks++;
    if (outs() !== (O_INCR | O_RFWE) || retired !== CW'(1) || illegal !== 1'b1 || pc_target !== 6'h3F) begin
      n_errors++;
      $display("FAIL async_pre: got outs=%b ret=%0d ill=%b tgt=%h required outs=%b ret=1 ill=1 tgt=3f",
               outs(), retired, illegal, pc_target, O_INCR | O_RFWE);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({outs(), retired, illegal, pc_target} !== '0) begin
      n_errors++;
      $display("FAIL async_clear: got outs=%b ret=%0d ill=%b tgt=%h required all zero",
               outs(), retired, illegal, pc_target);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    to_fetch();
    for (int n = 0; n < 17; n++) begin
      drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
      n_checks++;
      if (retired !== CW'((n < MAXR) ? n : MAXR)) begin
        n_errors++;
        $display("FAIL sat_count%0d: got %0d required %0d", n, retired, (n < MAXR) ? n : MAXR);
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, '0);
    n_checks++;
    if (retired !== 4'hF) begin
      n_errors++;
      $display("FAIL sat_hold: got %h required f", retired);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_sequence();
    test_branch();
    test_wait();
    test_wait_stall();
    test_illegal();
    test_random();
    test_halt();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
